// File: rtl/sync_fifo_pro.sv
// sync_fifo_pro: single-clock FIFO with arbitrary depth, occupancy/threshold flags, synchronous
// flush and registered (FWFT=0) or first-word-fall-through (FWFT=1) read. Define KOALA_FIFO_ERR_CHECK_EN for sticky error flags.
module sync_fifo_pro #(
  parameter int  DATA_WIDTH    = 64,
  parameter int  FIFO_DEPTH    = 4,
  parameter int  AFULL_THRESH  = FIFO_DEPTH - 1,
  parameter int  AEMPTY_THRESH = 1,
  parameter bit  FWFT          = 1'b0,
  localparam int CNT_W         = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush_i,
  input  logic                  wr_en_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  rd_en_i,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic                  rd_valid_o,
  output logic                  empty_o,
  output logic                  full_o,
  output logic                  almost_empty_o,
  output logic                  almost_full_o,
  output logic [CNT_W-1:0]      count_o,
  output logic                  overflow_o,
  output logic                  underflow_o
);

  localparam int               PTR_W      = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST   = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL   = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_AFULL  = CNT_W'(AFULL_THRESH);
  localparam logic [CNT_W-1:0] CNT_AEMPTY = CNT_W'(AEMPTY_THRESH);

  logic [DATA_WIDTH-1:0] mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_r;
  logic [PTR_W-1:0]      rd_ptr_r;
  logic [CNT_W-1:0]      count_r;
  logic                  empty_s;
  logic                  full_s;
  logic                  wr_accept_s;
  logic                  rd_accept_s;

  // Explicit wrap at FIFO_DEPTH-1 so any depth works, not only powers of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    if (ptr == PTR_LAST) begin
      return {PTR_W{1'b0}};
    end else begin
      return ptr + PTR_W'(1);
    end
  endfunction

  assign empty_s = (count_r == {CNT_W{1'b0}});
  assign full_s  = (count_r == CNT_FULL);

  // Accept qualification: full rejects writes and empty rejects reads, so there is no bypass.
  always_comb begin
    wr_accept_s = 1'b0;
    rd_accept_s = 1'b0;
    if (flush_i) begin
      wr_accept_s = 1'b0;
      rd_accept_s = 1'b0;
    end else begin
      wr_accept_s = wr_en_i && !full_s;
      rd_accept_s = rd_en_i && !empty_s;
    end
  end

  // Storage array, intentionally without reset.
  always_ff @(posedge clk) begin
    if (wr_accept_s) begin
      mem_r[wr_ptr_r] <= wr_data_i;
    end
  end

  // Pointers and occupancy count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else if (flush_i) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (wr_accept_s) begin
        wr_ptr_r <= ptr_inc(wr_ptr_r);
      end
      if (rd_accept_s) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end
      case ({wr_accept_s, rd_accept_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign count_o        = count_r;
  assign empty_o        = empty_s;
  assign full_o         = full_s;
  assign almost_empty_o = (count_r <= CNT_AEMPTY);
  assign almost_full_o  = (count_r >= CNT_AFULL);

  if (FWFT == 1'b0) begin : g_reg_read
    logic [DATA_WIDTH-1:0] rd_data_r;
    logic                  rd_valid_r;

    // Registered read port: data loads on an accepted pop, valid pulses the cycle after.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rd_data_r  <= {DATA_WIDTH{1'b0}};
        rd_valid_r <= 1'b0;
      end else begin
        rd_valid_r <= rd_accept_s;
        if (rd_accept_s) begin
          rd_data_r <= mem_r[rd_ptr_r];
        end
      end
    end

    assign rd_data_o  = rd_data_r;
    assign rd_valid_o = rd_valid_r;
  end else begin : g_fwft_read
    // Head entry is always presented; contents are don't-care while empty.
    assign rd_data_o  = mem_r[rd_ptr_r];
    assign rd_valid_o = !empty_s;
  end

`ifdef KOALA_FIFO_ERR_CHECK_EN
  logic overflow_r;
  logic underflow_r;

  // Sticky error flags; only rst_n clears them, flush does not.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      if (wr_en_i && full_s && !flush_i) begin
        overflow_r <= 1'b1;
      end
      if (rd_en_i && empty_s && !flush_i) begin
        underflow_r <= 1'b1;
      end
    end
  end

  assign overflow_o  = overflow_r;
  assign underflow_o = underflow_r;
`else
  assign overflow_o  = 1'b0;
  assign underflow_o = 1'b0;
`endif

endmodule
